mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer for the single synchronous SRAM-style memory port shared by instruction fetch (IF) and the data-memory access of the MEM stage. Accepts one access at a time, drives the bus, waits out slave wait-states, and returns read data and a one-cycle ack to the owning requester. Raises a pipeline stall while any request is outstanding. Returned data is unswizzled; byte-lane selection and sign extension stay in the write-back stage.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `STARVE_MAX`, default 4: number of consecutive data grants, while IF is waiting, after which IF is granted next.

Ports:
- `cpu_clk` in 1: single clock, rising edge.
- `cpu_rst_n` in 1: reset, asynchronous, active-low.
- `if_req` in 1: IF read request; held until `if_ack`.
- `if_addr` in ADDR_W: IF address.
- `if_rdata` out DATA_W: last IF read data, registered.
- `if_ack` out 1: one-cycle completion pulse for IF.
- `dm_req` in 1: data request; held until `dm_ack`.
- `dm_we` in 4: byte write enables; 0 means read.
- `dm_addr` in ADDR_W: data address.
- `dm_wdata` in DATA_W: data write value.
- `dm_rdata` out DATA_W: last data read value, registered.
- `dm_ack` out 1: one-cycle completion pulse for data.
- `bus_en` out 1: bus access strobe.
- `bus_we` out 4: bus byte write enables.
- `bus_addr` out ADDR_W: bus address.
- `bus_wdata` out DATA_W: bus write data.
- `bus_rdata` in DATA_W: slave read data, valid the cycle after the completing edge.
- `bus_wait` in 1: slave wait-state; the access is held while it is high.
- `stall_req` out 1: pipeline stall request.

## Operation
- FSM states: IDLE, BUSY, RESP. All `bus_*`, `*_ack` and `*_rdata` outputs are registered.
- **IDLE:**
  - Sample requests. A port's `req` is ignored in the cycle its own ack is high.
  - If one request is valid, grant it. If both are valid, grant data, unless `starve_cnt == STARVE_MAX`, in which case grant IF.
  - On a grant, load `bus_en=1`, `bus_addr`, `bus_we` and `bus_wdata` from the winner, record the owner, and go to BUSY. For IF, `bus_we=0` and `bus_wdata=0`.
- **BUSY:**
  - Bus outputs are held stable.
  - On an edge with `bus_wait=0`, clear `bus_en` and `bus_we` and go to RESP. Otherwise stay.
- **RESP:**
  - On the next edge, copy `bus_rdata` into the owner's `rdata` (reads only; writes leave `rdata` unchanged).
  - Pulse the owner's ack for one cycle and return to IDLE.
- **Starvation counter `starve_cnt`:**
  - Increments on a data grant made while `if_req` is high; saturates at `STARVE_MAX`.
  - Clears on any IF grant, and on any grant made while `if_req` is low.
- `stall_req = (if_req & ~if_ack) | (dm_req & ~dm_ack)`. This is combinational and must not depend on the FSM state.
- **Reset:**
  - State returns to IDLE and `starve_cnt` to 0.
  - All outputs go to 0: `bus_en`, `bus_we`, `bus_addr`, `bus_wdata`, both acks, and both rdata.
  - An in-flight access is abandoned; no ack is issued.

## Timing
- **Minimum latency** (request high in cycle 0, `bus_wait=0`):
  - `bus_en` is high in cycle 1.
  - RESP in cycle 2.
  - Ack and rdata valid in cycle 3.
  - Each wait-state adds one cycle.
- **Back-to-back accesses:** a new grant is possible at the end of the ack cycle, so `bus_en` rises again in cycle 4. Throughput is one access per 3 cycles.
- A change in `req`, address or data after the grant has no effect until the next grant.
- **Simultaneous requests with both arriving in the ack cycle:** the acked port's request is masked, so the other port wins that cycle.
- **Reset deasserted mid-cycle:** the first grant can occur on the first rising edge after `cpu_rst_n` goes high.

## Structure
- Shared constants go in `defines.v`: the FSM state codes, and owner encodings `OWN_IF` and `OWN_DM`.
- Reuse the existing `ZERO_WORD` and `RST_ENABLE` constants.
- One sub-module is natural: `mem_grant_sel`. It holds the combinational winner select and the saturating `starve_cnt` register. The top level holds the FSM and the output registers.

## Test plan
1. **Single data read:** `dm_req=1`, `dm_we=0`, `dm_addr=0x8000_0010`, slave returns `0x1122_3344` with no wait.
   - `bus_en` is high in cycle 1 only.
   - `dm_ack` pulses in cycle 3 with `dm_rdata=0x1122_3344`.
   - `stall_req` is high in cycles 0–2 and low in cycle 3.
2. **Data write with 2 wait-states:** `dm_we=4'b0011`, `dm_wdata=0xAABB_CCDD`.
   - Bus outputs are stable for 3 cycles.
   - `dm_ack` pulses in cycle 5.
   - `dm_rdata` is unchanged.
3. **Contention with `STARVE_MAX=4`:** `if_req` and `dm_req` both held high for 6 data accesses.
   - Grants are D,D,D,D,I,D.
   - `starve_cnt` reaches 4, then clears after the IF grant.
4. **Ack-cycle masking:** IF request pending alone, with `if_req` still high in its ack cycle.
   - There is no second IF grant.
   - A `dm_req` arriving in that same cycle is granted and `bus_en` rises in the next cycle.
5. **Reset mid-access:** `cpu_rst_n` driven low while in BUSY with `bus_wait=1`.
   - All outputs are 0 immediately.
   - No ack is ever issued.
   - After release, a new IF request completes in 3 cycles.
6. **Read then read:** IF reads `0x0`, then data reads `0x4`.
   - `if_rdata` keeps its value while `dm_rdata` updates.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter.
//   state_t    : sequencer states (idle, bus access, response)
//   owner_t    : which requester owns the access in flight
//   RST_ENABLE : level of the active-low reset
//   ZERO_WORD  : all-zero data word
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam logic        RST_ENABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

endpackage

// File: rtl/mem_port_arbiter_grant_sel.sv
// Winner select and starvation counter for the memory-port arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   if_valid   : IF request, already masked in its own ack cycle
//   dm_valid   : data request, already masked in its own ack cycle
//   if_req     : raw IF request (drives the starvation count)
//   grant_en   : arbiter is idle and may grant this cycle
//   grant      : some request is valid
//   grant_if   : IF wins (only meaningful when grant is high)
module mem_grant_sel
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_valid,
    input  logic dm_valid,
    input  logic if_req,
    input  logic grant_en,
    output logic grant,
    output logic grant_if
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    // Data has priority; IF wins a tie only once data has been favoured
    // STARVE_MAX times in a row while IF was asking.
    always_comb begin
        grant    = if_valid | dm_valid;
        grant_if = if_valid & (~dm_valid | starved);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            starve_cnt <= '0;
        end else if (grant_en && grant) begin
            if (grant_if || !if_req) begin
                starve_cnt <= '0;
            end else if (!starved) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the single memory port shared by instruction fetch
// and the MEM-stage data access. One access at a time: grant, drive the bus
// until the slave drops bus_wait, then return data and a one-cycle ack.
//   cpu_clk, cpu_rst_n            : clock, asynchronous active-low reset
//   if_req/if_addr                : IF read request (held until if_ack)
//   if_rdata/if_ack               : IF read data (registered), ack pulse
//   dm_req/dm_we/dm_addr/dm_wdata : data request, dm_we==0 means read
//   dm_rdata/dm_ack               : data read value (registered), ack pulse
//   bus_en/bus_we/bus_addr/bus_wdata : registered bus drive
//   bus_rdata/bus_wait            : slave read data and wait-state
//   stall_req                     : any request not yet acknowledged
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic [3:0]        dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              bus_en,
    output logic [3:0]        bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_wait,
    output logic              stall_req
);

    state_t state;
    owner_t owner;
    logic   is_read;
    logic   if_valid;
    logic   dm_valid;
    logic   grant;
    logic   grant_if;

    // A request is not new in the cycle its own ack is showing.
    assign if_valid  = if_req & ~if_ack;
    assign dm_valid  = dm_req & ~dm_ack;
    assign stall_req = if_valid | dm_valid;

    mem_grant_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant_sel (
        .clk      (cpu_clk),
        .rst_n    (cpu_rst_n),
        .if_valid (if_valid),
        .dm_valid (dm_valid),
        .if_req   (if_req),
        .grant_en (state == ST_IDLE),
        .grant    (grant),
        .grant_if (grant_if)
    );

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (cpu_rst_n == RST_ENABLE) begin
            state     <= ST_IDLE;
            owner     <= OWN_IF;
            is_read   <= 1'b0;
            bus_en    <= 1'b0;
            bus_we    <= '0;
            bus_addr  <= '0;
            bus_wdata <= DATA_W'(ZERO_WORD);
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= DATA_W'(ZERO_WORD);
            dm_rdata  <= DATA_W'(ZERO_WORD);
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        bus_en <= 1'b1;
                        state  <= ST_BUSY;
                        if (grant_if) begin
                            owner     <= OWN_IF;
                            is_read   <= 1'b1;
                            bus_we    <= '0;
                            bus_addr  <= if_addr;
                            bus_wdata <= DATA_W'(ZERO_WORD);
                        end else begin
                            owner     <= OWN_DM;
                            is_read   <= (dm_we == '0);
                            bus_we    <= dm_we;
                            bus_addr  <= dm_addr;
                            bus_wdata <= dm_wdata;
                        end
                    end
                end
                ST_BUSY: begin
                    // Address and write data stay on the bus after completion;
                    // only the strobes drop.
                    if (!bus_wait) begin
                        bus_en <= 1'b0;
                        bus_we <= '0;
                        state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (owner == OWN_IF) begin
                        if_ack   <= 1'b1;
                        if_rdata <= bus_rdata;
                    end else begin
                        dm_ack <= 1'b1;
                        if (is_read) begin
                            dm_rdata <= bus_rdata;
                        end
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of single accesses,
// directed multi-cycle corners (starvation, ack masking, reset mid-access)
// and randomized traffic, all checked every cycle against a
// transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int STARVE = 4;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        bus_en;
    logic [3:0]  bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_wait;
    logic        stall_req;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (STARVE)
    ) dut (
        .cpu_clk   (clk),
        .cpu_rst_n (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .bus_en    (bus_en),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_wait  (bus_wait),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrors = 0;

    // Reference model: one outstanding transaction described by who owns it,
    // whether it is a read, and how far along it is (0 none, 1 on the bus,
    // 2 waiting for the returned word).
    int          m_stage;
    bit          m_own_if;
    bit          m_read;
    int          m_starve;
    bit          m_bus_en;
    logic [3:0]  m_bus_we;
    logic [31:0] m_bus_addr;
    logic [31:0] m_bus_wdata;
    bit          m_if_ack;
    bit          m_dm_ack;
    logic [31:0] m_if_rdata;
    logic [31:0] m_dm_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stage = 0; m_own_if = 0; m_read = 0; m_starve = 0;
        m_bus_en = 0; m_bus_we = '0; m_bus_addr = '0; m_bus_wdata = '0;
        m_if_ack = 0; m_dm_ack = 0; m_if_rdata = '0; m_dm_rdata = '0;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        bit want_if, want_dm, pick_if;
        want_if = if_req && !m_if_ack;
        want_dm = dm_req && !m_dm_ack;
        m_if_ack = 0;
        m_dm_ack = 0;
        if (m_stage == 0) begin
            if (want_if || want_dm) begin
                pick_if = want_if && (!want_dm || m_starve == STARVE);
                if (pick_if || !if_req) m_starve = 0;
                else if (m_starve < STARVE) m_starve = m_starve + 1;
                m_own_if = pick_if;
                m_bus_en = 1;
                if (pick_if) begin
                    m_read = 1; m_bus_we = '0; m_bus_addr = if_addr; m_bus_wdata = '0;
                end else begin
                    m_read = (dm_we == 4'h0); m_bus_we = dm_we;
                    m_bus_addr = dm_addr; m_bus_wdata = dm_wdata;
                end
                m_stage = 1;
            end
        end else if (m_stage == 1) begin
            if (!bus_wait) begin
                m_bus_en = 0; m_bus_we = '0; m_stage = 2;
            end
        end else begin
            if (m_own_if) begin
                m_if_ack = 1; m_if_rdata = bus_rdata;
            end else begin
                m_dm_ack = 1;
                if (m_read) m_dm_rdata = bus_rdata;
            end
            m_stage = 0;
        end
    endtask

    task automatic check_outputs();
        chk("bus_en",    64'(bus_en),    64'(m_bus_en));
        chk("bus_we",    64'(bus_we),    64'(m_bus_we));
        chk("bus_addr",  64'(bus_addr),  64'(m_bus_addr));
        chk("bus_wdata", 64'(bus_wdata), 64'(m_bus_wdata));
        chk("if_ack",    64'(if_ack),    64'(m_if_ack));
        chk("dm_ack",    64'(dm_ack),    64'(m_dm_ack));
        chk("if_rdata",  64'(if_rdata),  64'(m_if_rdata));
        chk("dm_rdata",  64'(dm_rdata),  64'(m_dm_rdata));
    endtask

    // Inputs for the current cycle are already driven; check the stall
    // output, step the model and DUT across one edge, compare at the negedge.
    task automatic cycle();
        #1;
        chk("stall_req", 64'(stall_req),
            64'((if_req && !m_if_ack) || (dm_req && !m_dm_ack)));
        if (rst_n) model_edge();
        else model_reset();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    // Release requests once acked and run until everything is quiet.
    task automatic drain();
        bit quiet;
        quiet = 0;
        for (int k = 0; k < 60 && !quiet; k++) begin
            if (m_if_ack) if_req = 0;
            if (m_dm_ack) dm_req = 0;
            bus_wait = 0;
            if (!if_req && !dm_req && m_stage == 0 && !m_if_ack && !m_dm_ack) quiet = 1;
            else cycle();
        end
        chk("drain_quiet", 64'(quiet), 64'(1));
    endtask

    typedef struct {
        bit          is_if;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] slave_rdata;
        int          waits;
        int          exp_lat;
        int          exp_en_cycles;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_dm_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v, input int idx);
        int lat, en_cyc;
        lat = -1;
        en_cyc = 0;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            if (v.is_if) begin
                if_req = 1; if_addr = v.addr;
            end else begin
                dm_req = 1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
            end
            bus_wait  = (k >= 1 && k <= v.waits);
            bus_rdata = v.slave_rdata;
            cycle();
            if (bus_en) en_cyc++;
            if (v.is_if ? if_ack : dm_ack) lat = k + 1;
        end
        chk($sformatf("vec%0d_latency", idx),   64'(lat),      64'(v.exp_lat));
        chk($sformatf("vec%0d_bus_en_cyc", idx), 64'(en_cyc),  64'(v.exp_en_cycles));
        chk($sformatf("vec%0d_if_rdata", idx),  64'(if_rdata), 64'(v.exp_if_rdata));
        chk($sformatf("vec%0d_dm_rdata", idx),  64'(dm_rdata), 64'(v.exp_dm_rdata));
        if_req = 0;
        dm_req = 0;
        bus_wait = 0;
        cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        byte exp_order[6];
        byte got[$];
        bit  if_granted, if_done, prev_en;
        int  lat;

        rst_n = 0; if_req = 0; if_addr = '0; dm_req = 0; dm_we = '0;
        dm_addr = '0; dm_wdata = '0; bus_rdata = '0; bus_wait = 0;
        model_reset();

        // Reset values
        @(negedge clk);
        check_outputs();
        chk("reset_stall", 64'(stall_req), 64'(0));
        #2 rst_n = 1;

        // Single accesses: data read, data write with 2 waits, IF read,
        // data read with 1 wait, IF read with 3 waits.
        vecs[0] = '{0, 4'h0, 32'h8000_0010, 32'h0,          32'h1122_3344, 0, 3, 1, 32'h0,          32'h1122_3344};
        vecs[1] = '{0, 4'h3, 32'h8000_0020, 32'hAABB_CCDD,  32'hDEAD_BEEF, 2, 5, 3, 32'h0,          32'h1122_3344};
        vecs[2] = '{1, 4'h0, 32'h0000_0000, 32'h0,          32'h0000_0013, 0, 3, 1, 32'h0000_0013,  32'h1122_3344};
        vecs[3] = '{0, 4'h0, 32'h0000_0004, 32'h0,          32'h0BAD_F00D, 1, 4, 2, 32'h0000_0013,  32'h0BAD_F00D};
        vecs[4] = '{1, 4'h0, 32'h0000_0008, 32'h0,          32'hCAFE_0001, 3, 6, 4, 32'hCAFE_0001,  32'h0BAD_F00D};
        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Starvation: IF steps aside only in data ack cycles, so data keeps
        // winning ties until the count reaches STARVE.
        exp_order = '{"D", "D", "D", "D", "I", "D"};
        if_addr = 32'h100; dm_addr = 32'h200; dm_we = 4'h0;
        if_granted = 0; if_done = 0; prev_en = bus_en;
        for (int k = 0; k < 200 && got.size() < 6; k++) begin
            dm_req = 1;
            if_req = if_granted ? !if_done : !m_dm_ack;
            bus_wait = 0;
            bus_rdata = $urandom;
            cycle();
            if (bus_en && !prev_en) begin
                got.push_back(bus_addr == 32'h100 ? "I" : "D");
                if (bus_addr == 32'h100) if_granted = 1;
            end
            prev_en = bus_en;
            if (if_ack) if_done = 1;
        end
        chk("starve_grant_count", 64'(got.size()), 64'(6));
        for (int i = 0; i < got.size() && i < 6; i++)
            chk($sformatf("starve_grant%0d", i), 64'(got[i]), 64'(exp_order[i]));
        if (if_done) if_req = 0;
        drain();

        // Ack-cycle masking: IF still requesting in its ack cycle gets no
        // second grant.
        if_req = 1; if_addr = 32'h40;
        for (int k = 0; k < 20 && !if_ack; k++) cycle();
        chk("mask_if_ack_seen", 64'(if_ack), 64'(1));
        cycle();
        chk("mask_no_regrant", 64'(bus_en), 64'(0));
        if_req = 0;
        cycle();
        // Same again, with data arriving in the IF ack cycle: data wins.
        if_req = 1; if_addr = 32'h44;
        for (int k = 0; k < 20 && !if_ack; k++) cycle();
        chk("mask2_if_ack_seen", 64'(if_ack), 64'(1));
        dm_req = 1; dm_addr = 32'h50; dm_we = 4'h0;
        cycle();
        chk("mask2_dm_bus_en",   64'(bus_en),   64'(1));
        chk("mask2_dm_bus_addr", 64'(bus_addr), 64'(32'h50));
        if_req = 0;
        drain();

        // Reset in the middle of a waited write.
        dm_req = 1; dm_we = 4'hF; dm_addr = 32'h300; dm_wdata = 32'h5555_AAAA; bus_wait = 1;
        repeat (3) cycle();
        chk("rst_pre_bus_en", 64'(bus_en), 64'(1));
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("rst_bus_en",    64'(bus_en),    64'(0));
        chk("rst_bus_we",    64'(bus_we),    64'(0));
        chk("rst_bus_addr",  64'(bus_addr),  64'(0));
        chk("rst_bus_wdata", 64'(bus_wdata), 64'(0));
        chk("rst_acks",      64'({if_ack, dm_ack}), 64'(0));
        chk("rst_rdata",     64'({if_rdata, dm_rdata}), 64'(0));
        dm_req = 0; bus_wait = 0;
        repeat (2) cycle();
        if_req = 1; if_addr = 32'h44; bus_rdata = 32'h77;
        #2 rst_n = 1;
        lat = -1;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            cycle();
            if (if_ack) lat = k + 1;
        end
        chk("rst_after_if_lat",   64'(lat),      64'(3));
        chk("rst_after_if_rdata", 64'(if_rdata), 64'(32'h77));
        if_req = 0;
        cycle();

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            if (!(if_req && !m_if_ack)) begin
                if_req  = ($urandom_range(0, 2) == 0);
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!(dm_req && !m_dm_ack)) begin
                dm_req   = ($urandom_range(0, 2) == 0);
                dm_we    = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end
            bus_wait  = ($urandom_range(0, 2) == 0);
            bus_rdata = $urandom;
            cycle();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
        $finish;
    end

endmodule
